// File: rtl/apb_i2c_regfile_pkg.sv
// Shared constants for the I2C master APB front end: register indices,
// status bit positions (counted down from the MSB) and the access FSM states.
package i2c_apb_pkg;

  localparam logic [2:0] REG_PRESCALE   = 3'd1;
  localparam logic [2:0] REG_SLAVE_ADDR = 3'd2;
  localparam logic [2:0] REG_STATUS     = 3'd3;
  localparam logic [2:0] REG_TX         = 3'd4;
  localparam logic [2:0] REG_RX         = 3'd5;
  localparam logic [2:0] REG_CMD        = 3'd6;

  // Status flags live in the top bits; bit index = DATA_W - offset.
  localparam int STAT_TX_FULL_OFS  = 1;
  localparam int STAT_TX_EMPTY_OFS = 2;
  localparam int STAT_RX_FULL_OFS  = 3;
  localparam int STAT_RX_EMPTY_OFS = 4;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } apb_state_e;

endpackage

// File: rtl/apb_access_fsm.sv
// APB3 access-phase sequencer: state register plus saturating wait counter.
// PREADY is registered; commit/abort are decoded in the cycle they apply.
module apb_access_fsm
  import i2c_apb_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic pclk,
  input  logic presetn,
  input  logic psel,
  input  logic penable,
  output logic pready_o,
  output logic commit_o,
  output logic abort_o
);

  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_CYCLES);

  apb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pready_q, pready_d;
  logic             active;

  assign active = psel & penable;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    commit_o = 1'b0;
    abort_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          state_d = ST_ACCESS;
          cnt_d   = '0;
        end
      end
      ST_ACCESS: begin
        if (!active) begin
          abort_o = 1'b1;
          state_d = ST_IDLE;
        end else if (pready_q) begin
          commit_o = 1'b1;
          state_d  = ST_IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // PREADY for the coming cycle is known now, so it can be a flop output.
    pready_d = (state_d == ST_ACCESS) && (cnt_d == CNT_MAX);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pready_q <= pready_d;
    end
  end

  assign pready_o = pready_q;

endmodule

// File: rtl/apb_i2c_regfile.sv
// CPU-facing APB3 register file of the I2C master: decode, error checks,
// configuration registers, FIFO/command strobes and command self-clear.
module apb_i2c_regfile
  import i2c_apb_pkg::*;
#(
  parameter int                DATA_W       = 8,
  parameter int                ADDR_W       = 8,
  parameter int                WAIT_CYCLES  = 0,
  parameter logic [DATA_W-1:0] PRESCALE_RST = '0,
  parameter logic [DATA_W-1:0] CMD_SELFCLR  = 'h01
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [DATA_W-1:0] status_i,
  input  logic [DATA_W-1:0] rx_data_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_push_o,
  output logic              rx_pop_o,
  output logic [DATA_W-1:0] prescale_o,
  output logic [DATA_W-1:0] slave_addr_o,
  output logic [DATA_W-1:0] cmd_o,
  output logic              cmd_valid_o
);

  logic              pready, commit, abort;
  logic [2:0]        reg_idx;
  logic              err, ok_commit;
  logic [DATA_W-1:0] rd_mux;
  logic              unused_ok;

  logic [DATA_W-1:0] prescale_q, prescale_d;
  logic [DATA_W-1:0] slave_addr_q, slave_addr_d;
  logic [DATA_W-1:0] cmd_q, cmd_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_push_q, tx_push_d;
  logic              rx_pop_q, rx_pop_d;
  logic              cmd_valid_q, cmd_valid_d;

  apb_access_fsm #(.WAIT_CYCLES(WAIT_CYCLES)) u_fsm (
    .pclk     (PCLK),
    .presetn  (PRESETn),
    .psel     (PSEL),
    .penable  (PENABLE),
    .pready_o (pready),
    .commit_o (commit),
    .abort_o  (abort)
  );

  assign reg_idx   = PADDR[ADDR_W-1 -: 3];
  assign unused_ok = ^{abort, PADDR};

  // Error and read mux use status_i live, so a flag change in the
  // completing cycle decides the outcome.
  always_comb begin
    err    = 1'b0;
    rd_mux = '0;
    case (reg_idx)
      REG_PRESCALE:   rd_mux = prescale_q;
      REG_SLAVE_ADDR: rd_mux = slave_addr_q;
      REG_CMD:        rd_mux = cmd_q;
      REG_STATUS: begin
        err    = PWRITE;
        rd_mux = status_i;
      end
      REG_TX: err = !PWRITE || status_i[DATA_W-STAT_TX_FULL_OFS];
      REG_RX: begin
        err    = PWRITE || status_i[DATA_W-STAT_RX_EMPTY_OFS];
        rd_mux = rx_data_i;
      end
      default: err = 1'b1;
    endcase
  end

  assign ok_commit = commit & ~err;
  assign PREADY    = pready;
  assign PSLVERR   = pready & err;
  assign PRDATA    = (pready && PSEL && PENABLE && !PWRITE && !err) ? rd_mux : '0;

  always_comb begin
    prescale_d   = prescale_q;
    slave_addr_d = slave_addr_q;
    cmd_d        = cmd_valid_q ? (cmd_q & ~CMD_SELFCLR) : cmd_q;
    tx_data_d    = tx_data_q;
    tx_push_d    = 1'b0;
    rx_pop_d     = 1'b0;
    cmd_valid_d  = 1'b0;
    if (ok_commit) begin
      if (PWRITE) begin
        case (reg_idx)
          REG_PRESCALE:   prescale_d   = PWDATA;
          REG_SLAVE_ADDR: slave_addr_d = PWDATA;
          REG_TX: begin
            tx_data_d = PWDATA;
            tx_push_d = 1'b1;
          end
          REG_CMD: begin
            cmd_d       = PWDATA;
            cmd_valid_d = 1'b1;
          end
          default: ;
        endcase
      end else if (reg_idx == REG_RX) begin
        rx_pop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      prescale_q   <= PRESCALE_RST;
      slave_addr_q <= '0;
      cmd_q        <= '0;
      tx_data_q    <= '0;
      tx_push_q    <= 1'b0;
      rx_pop_q     <= 1'b0;
      cmd_valid_q  <= 1'b0;
    end else begin
      prescale_q   <= prescale_d;
      slave_addr_q <= slave_addr_d;
      cmd_q        <= cmd_d;
      tx_data_q    <= tx_data_d;
      tx_push_q    <= tx_push_d;
      rx_pop_q     <= rx_pop_d;
      cmd_valid_q  <= cmd_valid_d;
    end
  end

  assign prescale_o   = prescale_q;
  assign slave_addr_o = slave_addr_q;
  assign cmd_o        = cmd_q;
  assign tx_data_o    = tx_data_q;
  assign tx_push_o    = tx_push_q;
  assign rx_pop_o     = rx_pop_q;
  assign cmd_valid_o  = cmd_valid_q;

endmodule

// File: tb/tb_apb_i2c_regfile.sv
// Directed bench for apb_i2c_regfile: three instances with 0, 2 and 3 wait
// states share the clock and reset; each has its own APB and side signals.
module tb_apb_i2c_regfile;

  logic       PCLK;
  logic       PRESETn;
  logic       psel[3], penable[3], pwrite[3];
  logic [7:0] paddr[3], pwdata[3], prdata[3], status[3], rxd[3];
  logic       pready[3], pslverr[3], txp[3], rxp[3], cmdv[3];
  logic [7:0] txd[3], pres[3], slv[3], cmd[3];

  int checks = 0;
  int errors = 0;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_i2c_regfile #(
      .DATA_W       (8),
      .ADDR_W       (8),
      .WAIT_CYCLES  ((g == 0) ? 0 : ((g == 1) ? 2 : 3)),
      .PRESCALE_RST (8'h17),
      .CMD_SELFCLR  (8'h01)
    ) u_dut (
      .PCLK         (PCLK),
      .PRESETn      (PRESETn),
      .PSEL         (psel[g]),
      .PENABLE      (penable[g]),
      .PWRITE       (pwrite[g]),
      .PADDR        (paddr[g]),
      .PWDATA       (pwdata[g]),
      .PRDATA       (prdata[g]),
      .PREADY       (pready[g]),
      .PSLVERR      (pslverr[g]),
      .status_i     (status[g]),
      .rx_data_i    (rxd[g]),
      .tx_data_o    (txd[g]),
      .tx_push_o    (txp[g]),
      .rx_pop_o     (rxp[g]),
      .prescale_o   (pres[g]),
      .slave_addr_o (slv[g]),
      .cmd_o        (cmd[g]),
      .cmd_valid_o  (cmdv[g])
    );
  end

  // Runs one transfer and returns at the completing cycle's negedge,
  // leaving PSEL/PENABLE high so a following call is back-to-back.
  task automatic do_xfer(input int i, input logic wr, input logic [7:0] addr,
                         input logic [7:0] wdata, output logic [7:0] rdata,
                         output logic err, output int acc);
    @(negedge PCLK);
    psel[i] = 1'b1; penable[i] = 1'b0; pwrite[i] = wr;
    paddr[i] = addr; pwdata[i] = wdata;
    @(negedge PCLK);
    penable[i] = 1'b1;
    #1;
    acc = 1;
    while (!pready[i] && acc < 40) begin
      @(negedge PCLK); #1;
      acc++;
    end
    checks++;
    if (pready[i] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL xfer_timeout inst%0d addr=%h: PREADY=%b after %0d cycles, need 1", i, addr, pready[i], acc);
    end
    rdata = prdata[i];
    err   = pslverr[i];
  endtask

  task automatic bus_idle(input int i);
    @(negedge PCLK);
    psel[i] = 1'b0; penable[i] = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      psel[i] = 0; penable[i] = 0; pwrite[i] = 0; paddr[i] = 0;
      pwdata[i] = 0; status[i] = 0; rxd[i] = 0;
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({pready[i], pslverr[i], txp[i], rxp[i], cmdv[i]} !== 5'b0) begin
        errors++;
        $display("[TB] FAIL reset_ctrl inst%0d: got %b, need 00000", i, {pready[i], pslverr[i], txp[i], rxp[i], cmdv[i]});
      end
      checks++;
      if ({prdata[i], txd[i], slv[i], cmd[i]} !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_data inst%0d: got %h, need 0", i, {prdata[i], txd[i], slv[i], cmd[i]});
      end
      checks++;
      if (pres[i] !== 8'h17) begin
        errors++;
        $display("[TB] FAIL reset_prescale inst%0d: got %h, need 17", i, pres[i]);
      end
    end
    @(negedge PCLK);
    PRESETn = 1'b1;
  endtask

  task automatic test_zero_wait_write();
    logic [7:0] rd; logic er; int acc;
    do_xfer(0, 1'b1, 8'h20, 8'h2A, rd, er, acc);
    checks++;
    if (acc !== 1) begin errors++; $display("[TB] FAIL w0_latency: got %0d access cycles, need 1", acc); end
    checks++;
    if (er !== 1'b0 || rd !== 8'h00) begin errors++; $display("[TB] FAIL w0_resp: err=%b rdata=%h, need 0/00", er, rd); end
    checks++;
    if (pres[0] !== 8'h17) begin errors++; $display("[TB] FAIL w0_before_edge: prescale=%h, need 17", pres[0]); end
    bus_idle(0);
    checks++;
    if (pres[0] !== 8'h2A) begin errors++; $display("[TB] FAIL w0_prescale: got %h, need 2A", pres[0]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd; logic er; int acc;
    status[0] = 8'hA5;
    do_xfer(0, 1'b1, 8'h40, 8'h55, rd, er, acc);
    do_xfer(0, 1'b0, 8'h40, 8'h00, rd, er, acc);
    checks++;
    if (rd !== 8'h55 || er !== 1'b0 || acc !== 1) begin
      errors++; $display("[TB] FAIL b2b_slave_read: rdata=%h err=%b acc=%0d, need 55/0/1", rd, er, acc);
    end
    do_xfer(0, 1'b0, 8'h20, 8'h00, rd, er, acc);
    checks++;
    if (rd !== 8'h2A || er !== 1'b0) begin errors++; $display("[TB] FAIL b2b_prescale_read: rdata=%h err=%b, need 2A/0", rd, er); end
    do_xfer(0, 1'b0, 8'h60, 8'h00, rd, er, acc);
    checks++;
    if (rd !== 8'hA5 || er !== 1'b0) begin errors++; $display("[TB] FAIL status_read: rdata=%h err=%b, need A5/0", rd, er); end
    bus_idle(0);
    checks++;
    if (prdata[0] !== 8'h00 || pready[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_outputs: prdata=%h pready=%b, need 00/0", prdata[0], pready[0]);
    end
    status[0] = 8'h00;
  endtask

  task automatic test_tx();
    logic [7:0] rd; logic er; int acc;
    status[1] = 8'h00;
    do_xfer(1, 1'b1, 8'h80, 8'h5A, rd, er, acc);
    checks++;
    if (acc !== 3 || er !== 1'b0) begin errors++; $display("[TB] FAIL tx_latency: acc=%0d err=%b, need 3/0", acc, er); end
    checks++;
    if (txp[1] !== 1'b0) begin errors++; $display("[TB] FAIL tx_push_early: got %b, need 0", txp[1]); end
    bus_idle(1);
    checks++;
    if (txp[1] !== 1'b1 || txd[1] !== 8'h5A) begin errors++; $display("[TB] FAIL tx_push: push=%b data=%h, need 1/5A", txp[1], txd[1]); end
    @(negedge PCLK); #1;
    checks++;
    if (txp[1] !== 1'b0) begin errors++; $display("[TB] FAIL tx_push_width: got %b, need 0", txp[1]); end
    status[1] = 8'h80;
    do_xfer(1, 1'b1, 8'h80, 8'hC3, rd, er, acc);
    checks++;
    if (er !== 1'b1) begin errors++; $display("[TB] FAIL tx_full_err: got %b, need 1", er); end
    bus_idle(1);
    checks++;
    if (txp[1] !== 1'b0 || txd[1] !== 8'h5A) begin errors++; $display("[TB] FAIL tx_full_noside: push=%b data=%h, need 0/5A", txp[1], txd[1]); end
    status[1] = 8'h00;
    do_xfer(1, 1'b0, 8'h80, 8'h00, rd, er, acc);
    checks++;
    if (er !== 1'b1 || rd !== 8'h00) begin errors++; $display("[TB] FAIL tx_read_err: err=%b rdata=%h, need 1/00", er, rd); end
    bus_idle(1);
  endtask

  task automatic test_rx();
    logic [7:0] rd; logic er; int acc;
    status[1] = 8'h00; rxd[1] = 8'h3C;
    do_xfer(1, 1'b0, 8'hA0, 8'h00, rd, er, acc);
    checks++;
    if (rd !== 8'h3C || er !== 1'b0) begin errors++; $display("[TB] FAIL rx_read: rdata=%h err=%b, need 3C/0", rd, er); end
    bus_idle(1);
    checks++;
    if (rxp[1] !== 1'b1) begin errors++; $display("[TB] FAIL rx_pop: got %b, need 1", rxp[1]); end
    @(negedge PCLK); #1;
    checks++;
    if (rxp[1] !== 1'b0) begin errors++; $display("[TB] FAIL rx_pop_width: got %b, need 0", rxp[1]); end
    status[1] = 8'h10;
    do_xfer(1, 1'b0, 8'hA0, 8'h00, rd, er, acc);
    checks++;
    if (rd !== 8'h00 || er !== 1'b1) begin errors++; $display("[TB] FAIL rx_empty: rdata=%h err=%b, need 00/1", rd, er); end
    bus_idle(1);
    checks++;
    if (rxp[1] !== 1'b0) begin errors++; $display("[TB] FAIL rx_empty_nopop: got %b, need 0", rxp[1]); end
    status[1] = 8'h00;
    do_xfer(1, 1'b1, 8'hA0, 8'hFF, rd, er, acc);
    checks++;
    if (er !== 1'b1) begin errors++; $display("[TB] FAIL rx_write_err: got %b, need 1", er); end
    bus_idle(1);
  endtask

  task automatic test_cmd();
    logic [7:0] rd; logic er; int acc;
    do_xfer(0, 1'b1, 8'hC0, 8'h91, rd, er, acc);
    checks++;
    if (er !== 1'b0) begin errors++; $display("[TB] FAIL cmd_err: got %b, need 0", er); end
    bus_idle(0);
    checks++;
    if (cmdv[0] !== 1'b1 || cmd[0] !== 8'h91) begin errors++; $display("[TB] FAIL cmd_write: valid=%b cmd=%h, need 1/91", cmdv[0], cmd[0]); end
    @(negedge PCLK); #1;
    checks++;
    if (cmdv[0] !== 1'b0 || cmd[0] !== 8'h90) begin errors++; $display("[TB] FAIL cmd_selfclr: valid=%b cmd=%h, need 0/90", cmdv[0], cmd[0]); end
    do_xfer(0, 1'b0, 8'hC0, 8'h00, rd, er, acc);
    checks++;
    if (rd !== 8'h90) begin errors++; $display("[TB] FAIL cmd_read: got %h, need 90", rd); end
    bus_idle(0);
  endtask

  task automatic test_bad_access();
    logic [7:0] rd; logic er; int acc;
    logic [7:0] bad_addr[3];
    bad_addr[0] = 8'h60; bad_addr[1] = 8'hE0; bad_addr[2] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      do_xfer(0, 1'b1, bad_addr[k], 8'hFF, rd, er, acc);
      checks++;
      if (er !== 1'b1) begin errors++; $display("[TB] FAIL bad_write_err addr=%h: got %b, need 1", bad_addr[k], er); end
      bus_idle(0);
      checks++;
      if ({pres[0], slv[0], cmd[0], txd[0]} !== 32'h2A559000 || {txp[0], rxp[0], cmdv[0]} !== 3'b0) begin
        errors++; $display("[TB] FAIL bad_write_noside addr=%h: regs=%h strobes=%b", bad_addr[k], {pres[0], slv[0], cmd[0], txd[0]}, {txp[0], rxp[0], cmdv[0]});
      end
    end
    do_xfer(0, 1'b0, 8'hE0, 8'h00, rd, er, acc);
    checks++;
    if (er !== 1'b1 || rd !== 8'h00) begin errors++; $display("[TB] FAIL unmapped_read: err=%b rdata=%h, need 1/00", er, rd); end
    bus_idle(0);
  endtask

  task automatic test_abort();
    logic [7:0] rd; logic er; int acc;
    status[2] = 8'h00;
    @(negedge PCLK);
    psel[2] = 1; penable[2] = 0; pwrite[2] = 1; paddr[2] = 8'h80; pwdata[2] = 8'hEE;
    @(negedge PCLK);
    penable[2] = 1;
    @(negedge PCLK);
    psel[2] = 0; penable[2] = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge PCLK); #1;
      checks++;
      if (pready[2] !== 1'b0 || txp[2] !== 1'b0 || txd[2] !== 8'h00) begin
        errors++; $display("[TB] FAIL abort_noside cyc%0d: pready=%b push=%b data=%h", k, pready[2], txp[2], txd[2]);
      end
    end
    do_xfer(2, 1'b1, 8'h80, 8'h61, rd, er, acc);
    checks++;
    if (acc !== 4 || er !== 1'b0) begin errors++; $display("[TB] FAIL abort_next_latency: acc=%0d err=%b, need 4/0", acc, er); end
    do_xfer(2, 1'b0, 8'h40, 8'h00, rd, er, acc);
    checks++;
    if (acc !== 4 || rd !== 8'h00 || er !== 1'b0) begin errors++; $display("[TB] FAIL abort_b2b: acc=%0d rdata=%h err=%b, need 4/00/0", acc, rd, er); end
    bus_idle(2);
    checks++;
    if (txd[2] !== 8'h61) begin errors++; $display("[TB] FAIL abort_after_tx: got %h, need 61", txd[2]); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd; logic er; int acc;
    @(negedge PCLK);
    psel[0] = 1; penable[0] = 0; pwrite[0] = 1; paddr[0] = 8'h20; pwdata[0] = 8'h77;
    @(negedge PCLK);
    penable[0] = 1;
    #1;
    checks++;
    if (pready[0] !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_ready: got %b, need 1", pready[0]); end
    PRESETn = 1'b0;
    #1;
    checks++;
    if (pready[0] !== 1'b0 || pres[0] !== 8'h17 || {slv[0], cmd[0]} !== 16'h0) begin
      errors++; $display("[TB] FAIL rst_async: pready=%b prescale=%h slv_cmd=%h, need 0/17/0000", pready[0], pres[0], {slv[0], cmd[0]});
    end
    psel[0] = 0; penable[0] = 0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK); #1;
    checks++;
    if (pres[0] !== 8'h17) begin errors++; $display("[TB] FAIL rst_lost_xfer: prescale=%h, need 17", pres[0]); end
    do_xfer(0, 1'b1, 8'h20, 8'h33, rd, er, acc);
    bus_idle(0);
    checks++;
    if (pres[0] !== 8'h33 || er !== 1'b0 || acc !== 1) begin
      errors++; $display("[TB] FAIL rst_first_xfer: prescale=%h err=%b acc=%0d, need 33/0/1", pres[0], er, acc);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_write();
    test_back_to_back();
    test_tx();
    test_rx();
    test_cmd();
    test_bad_access();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
